// File: rtl/axil_mem_arbiter.sv
// Round-robin arbiter that serializes held wen/ren requests from several AXIL-to-memory
// bridges onto one held-enable memory port, with a per-access timeout.
module axil_mem_arbiter #(
  parameter int num_clients_p    = 2,
  parameter int mem_addr_width_p = 8,   // no meaningful default; override at instantiation
  parameter int timeout_p        = 64
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic [num_clients_p*mem_addr_width_p-1:0] addr_i,
  input  logic [num_clients_p*32-1:0]               wdata_i,
  input  logic [num_clients_p-1:0]                  wen_i,
  input  logic [num_clients_p-1:0]                  ren_i,
  output logic [num_clients_p-1:0]                  done_o,
  output logic [31:0]                               rdata_o,
  output logic                                      timeout_o,
  output logic [mem_addr_width_p-1:0]               mem_addr_o,
  output logic [31:0]                               mem_wdata_o,
  output logic                                      mem_wen_o,
  output logic                                      mem_ren_o,
  input  logic [31:0]                               mem_rdata_i,
  input  logic                                      mem_done_i
);

  localparam int idx_w = $clog2(num_clients_p);
  localparam int cnt_w = (timeout_p > 0) ? $clog2(timeout_p + 1) : 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'((timeout_p > 0) ? timeout_p - 1 : 0);
  localparam logic [cnt_w-1:0] cnt_max  = '1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                      state;
  logic [idx_w-1:0]            last_r;
  logic [cnt_w-1:0]            cnt;
  logic                        to_flag;

  logic [num_clients_p-1:0]    req;
  logic                        grant_found;
  logic [idx_w-1:0]            grant_idx;
  logic [mem_addr_width_p-1:0] sel_addr;
  logic [31:0]                 sel_wdata;
  logic                        sel_wen;

  assign req = wen_i | ren_i;

  // Search starts one past the last winner so every requester is reached within one rotation.
  always_comb begin
    int               j;
    logic [idx_w-1:0] cand;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    j           = 0;
    cand        = '0;
    for (int k = 1; k <= num_clients_p; k++) begin
      j = int'(last_r) + k;
      if (j >= num_clients_p) j = j - num_clients_p;
      cand = idx_w'(j);
      if (!grant_found && req[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wen   = 1'b0;
    for (int i = 0; i < num_clients_p; i++) begin
      if (grant_idx == idx_w'(i)) begin
        sel_addr  = addr_i[i*mem_addr_width_p +: mem_addr_width_p];
        sel_wdata = wdata_i[i*32 +: 32];
        sel_wen   = wen_i[i];
      end
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= IDLE;
      last_r      <= idx_w'(num_clients_p - 1);
      cnt         <= '0;
      to_flag     <= 1'b0;
      rdata_o     <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_wen_o   <= 1'b0;
      mem_ren_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            // Write wins when a client raises both enables; the enables then hold the op.
            last_r      <= grant_idx;
            mem_addr_o  <= sel_addr;
            mem_wdata_o <= sel_wdata;
            mem_wen_o   <= sel_wen;
            mem_ren_o   <= !sel_wen;
            cnt         <= '0;
            to_flag     <= 1'b0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (mem_done_i) begin
            if (mem_ren_o) rdata_o <= mem_rdata_i;
            mem_wen_o <= 1'b0;
            mem_ren_o <= 1'b0;
            state     <= RESP;
          end else if (timeout_p != 0 && cnt == cnt_last) begin
            to_flag   <= 1'b1;
            if (mem_ren_o) rdata_o <= 32'hdead_beef;
            mem_wen_o <= 1'b0;
            mem_ren_o <= 1'b0;
            state     <= RESP;
          end else if (cnt != cnt_max) begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    done_o = '0;
    if (state == RESP) done_o[last_r] = 1'b1;
  end

  assign timeout_o = (state == RESP) && to_flag;

endmodule

// File: tb/tb_axil_mem_arbiter.sv
// Scoreboard bench for axil_mem_arbiter: expected accesses are queued in grant order and
// compared when the shared port starts an access and when the done pulse appears.
module tb_axil_mem_arbiter;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int TO = 8;

  logic           clk_i = 1'b0;
  logic           reset_i;
  logic [N*W-1:0] addr_i;
  logic [N*32-1:0] wdata_i;
  logic [N-1:0]   wen_i, ren_i, done_o;
  logic [31:0]    rdata_o, mem_wdata_o, mem_rdata_i;
  logic           timeout_o, mem_wen_o, mem_ren_o, mem_done_i;
  logic [W-1:0]   mem_addr_o;

  logic [W-1:0]   c_addr [N];
  logic [31:0]    c_wdata[N];
  logic           c_wen  [N];
  logic           c_ren  [N];

  int             checks   = 0;
  int             failures = 0;
  int             resp_delay = 1;
  logic [31:0]    tgt_rdata  = '0;
  int             tgt_cnt;

  typedef struct {
    int          client;
    bit          rd;
    logic [W-1:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          to;
  } exp_t;
  exp_t sb_q[$];

  axil_mem_arbiter #(
    .num_clients_p(N), .mem_addr_width_p(W), .timeout_p(TO)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .wen_i(wen_i), .ren_i(ren_i), .done_o(done_o), .rdata_o(rdata_o),
    .timeout_o(timeout_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wen_o(mem_wen_o), .mem_ren_o(mem_ren_o), .mem_rdata_i(mem_rdata_i),
    .mem_done_i(mem_done_i)
  );

  always #5 clk_i = ~clk_i;

  always_comb begin
    addr_i  = '0;
    wdata_i = '0;
    wen_i   = '0;
    ren_i   = '0;
    for (int i = 0; i < N; i++) begin
      addr_i[i*W +: W]   = c_addr[i];
      wdata_i[i*32 +: 32] = c_wdata[i];
      wen_i[i]           = c_wen[i];
      ren_i[i]           = c_ren[i];
    end
  end

  // Target: answers resp_delay cycles after the enable first appears.
  always @(posedge clk_i) begin
    mem_done_i <= 1'b0;
    if (reset_i || !(mem_wen_o || mem_ren_o) || mem_done_i) begin
      tgt_cnt <= 0;
    end else if (tgt_cnt == resp_delay - 1) begin
      mem_done_i  <= 1'b1;
      mem_rdata_i <= tgt_rdata;
      tgt_cnt     <= 0;
    end else begin
      tgt_cnt <= tgt_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int c, input bit rd, input logic [W-1:0] a,
                          input logic [31:0] d, input logic [31:0] r, input bit to);
    exp_t e;
    e.client = c; e.rd = rd; e.addr = a; e.wdata = d; e.rdata = r; e.to = to;
    sb_q.push_back(e);
  endtask

  // Raise a held request, wait (bounded) for the done pulse, drop it the cycle after.
  task automatic client_access(input int c, input bit rd, input logic [W-1:0] a,
                               input logic [31:0] d, output int lat);
    @(posedge clk_i); #1;
    c_addr[c] = a; c_wdata[c] = d; c_wen[c] = !rd; c_ren[c] = rd;
    lat = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk_i);
      if (done_o[c]) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) check($sformatf("done_wait_c%0d", c), 32'd0, 32'd1);
    @(posedge clk_i); #1;
    c_wen[c] = 1'b0; c_ren[c] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
    sb_q.delete();
  endtask

  // Scoreboard monitor: access start checks the port, done pulse pops and checks the response.
  initial begin
    bit prev_en = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!reset_i) begin
        if ((mem_wen_o || mem_ren_o) && !prev_en) begin
          if (sb_q.size() == 0) begin
            check("unexpected_access", 32'd1, 32'd0);
          end else begin
            check("mem_addr", 32'(mem_addr_o), 32'(sb_q[0].addr));
            check("mem_op_rd", 32'(mem_ren_o), 32'(sb_q[0].rd));
            if (!sb_q[0].rd) check("mem_wdata", mem_wdata_o, sb_q[0].wdata);
          end
        end
        if (done_o != '0) begin
          if (sb_q.size() == 0) begin
            check("unexpected_done", 32'(done_o), 32'd0);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("done_onehot", 32'(done_o), 32'd1 << e.client);
            check("timeout_flag", 32'(timeout_o), 32'(e.to));
            if (e.rd) check("rdata", rdata_o, e.rdata);
          end
        end
      end
      prev_en = mem_wen_o || mem_ren_o;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int l0, l1, l2, lat;
    for (int i = 0; i < N; i++) begin
      c_addr[i] = '0; c_wdata[i] = '0; c_wen[i] = 1'b0; c_ren[i] = 1'b0;
    end
    reset_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_timeout", 32'(timeout_o), 32'd0);
    check("rst_wen", 32'(mem_wen_o), 32'd0);
    check("rst_ren", 32'(mem_ren_o), 32'd0);
    check("rst_addr", 32'(mem_addr_o), 32'd0);
    check("rst_wdata", mem_wdata_o, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    @(posedge clk_i); #1 reset_i = 1'b0;

    // Single read from client 1, target answers two cycles after the enable.
    resp_delay = 2; tgt_rdata = 32'hCAFE_0001;
    push_exp(1, 1'b1, 8'h10, 32'h0, 32'hCAFE_0001, 1'b0);
    client_access(1, 1'b1, 8'h10, 32'h0, lat);
    check("t1_latency", 32'(lat), 32'd4);

    // Simultaneous writes after reset: client 0 first, then client 1.
    do_reset();
    resp_delay = 1;
    push_exp(0, 1'b0, 8'h30, 32'hAAAA_0000, 32'h0, 1'b0);
    push_exp(1, 1'b0, 8'h31, 32'hBBBB_1111, 32'h0, 1'b0);
    fork
      client_access(0, 1'b0, 8'h30, 32'hAAAA_0000, l0);
      client_access(1, 1'b0, 8'h31, 32'hBBBB_1111, l1);
    join

    // Three persistent requesters: grant order 0,1,2,0,1,2.
    do_reset();
    resp_delay = 2; tgt_rdata = 32'h1234_5678;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < N; c++)
        push_exp(c, c == 2, 8'(8'h20 + 4*r + c), 32'h100 * (r + 1) + 32'(c), 32'h1234_5678, 1'b0);
    fork
      for (int r = 0; r < 2; r++) client_access(0, 1'b0, 8'(8'h20 + 4*r), 32'h100 * (r + 1), l0);
      for (int r = 0; r < 2; r++) client_access(1, 1'b0, 8'(8'h21 + 4*r), 32'h100 * (r + 1) + 1, l1);
      for (int r = 0; r < 2; r++) client_access(2, 1'b1, 8'(8'h22 + 4*r), 32'h100 * (r + 1) + 2, l2);
    join

    // Target never answers: forced completion after TO busy cycles.
    resp_delay = 1000;
    push_exp(0, 1'b1, 8'h40, 32'h0, 32'hdead_beef, 1'b1);
    client_access(0, 1'b1, 8'h40, 32'h0, lat);
    check("t4_timeout_latency", 32'(lat), 32'(TO + 1));

    // Next access after a timeout is served normally, at minimum latency.
    resp_delay = 1; tgt_rdata = 32'h600D_0002;
    push_exp(2, 1'b1, 8'h41, 32'h0, 32'h600D_0002, 1'b0);
    client_access(2, 1'b1, 8'h41, 32'h0, lat);
    check("t4_next_latency", 32'(lat), 32'd3);

    // Completion in the last counted cycle beats the timeout.
    resp_delay = TO - 1; tgt_rdata = 32'h5555_AAAA;
    push_exp(1, 1'b1, 8'h42, 32'h0, 32'h5555_AAAA, 1'b0);
    client_access(1, 1'b1, 8'h42, 32'h0, lat);
    check("t5_edge_latency", 32'(lat), 32'(TO + 1));

    // Reset while BUSY abandons the access without a done pulse.
    resp_delay = 1000;
    push_exp(1, 1'b0, 8'h50, 32'h5050_5050, 32'h0, 1'b0);
    @(posedge clk_i); #1;
    c_addr[1] = 8'h50; c_wdata[1] = 32'h5050_5050; c_wen[1] = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check("t6_wen_after_rst", 32'(mem_wen_o), 32'd0);
    check("t6_ren_after_rst", 32'(mem_ren_o), 32'd0);
    check("t6_done_after_rst", 32'(done_o), 32'd0);
    c_wen[1] = 1'b0;
    sb_q.delete();
    @(posedge clk_i); #1 reset_i = 1'b0;
    resp_delay = 1;
    push_exp(0, 1'b0, 8'h60, 32'h6000_0000, 32'h0, 1'b0);
    push_exp(1, 1'b0, 8'h61, 32'h6111_1111, 32'h0, 1'b0);
    fork
      client_access(0, 1'b0, 8'h60, 32'h6000_0000, l0);
      client_access(1, 1'b0, 8'h61, 32'h6111_1111, l1);
    join

    repeat (3) @(posedge clk_i);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
